// File: rtl/saper_pkg.sv
// saper_pkg: shared minesweeper constants, level helpers, generator FSM states and LFSR taps.
package saper_pkg;
   localparam logic [1:0] LVL_NONE   = 2'd0;
   localparam logic [1:0] LVL_EASY   = 2'd1;
   localparam logic [1:0] LVL_MEDIUM = 2'd2;
   localparam logic [1:0] LVL_HARD   = 2'd3;
   localparam logic [4:0] BOARD_SIZE_EASY   = 5'd8;
   localparam logic [4:0] BOARD_SIZE_MEDIUM = 5'd10;
   localparam logic [4:0] BOARD_SIZE_HARD   = 5'd16;
   localparam logic [5:0] MINES_EASY   = 6'd10;
   localparam logic [5:0] MINES_MEDIUM = 6'd15;
   localparam logic [5:0] MINES_HARD   = 6'd40;
   // Right-shifting Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5).
   localparam logic [15:0] LFSR_TAPS = 16'h002D;
   typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DRAW, ST_DONE} gen_state_t;
   function automatic logic [4:0] board_size(input logic [1:0] lvl);
      return lvl == LVL_EASY ? BOARD_SIZE_EASY : lvl == LVL_MEDIUM ? BOARD_SIZE_MEDIUM :
             lvl == LVL_HARD ? BOARD_SIZE_HARD : 5'd0;
   endfunction
   function automatic logic [5:0] mine_target(input logic [1:0] lvl);
      return lvl == LVL_EASY ? MINES_EASY : lvl == LVL_MEDIUM ? MINES_MEDIUM :
             lvl == LVL_HARD ? MINES_HARD : 6'd0;
   endfunction
endpackage

// File: rtl/mine_lfsr.sv
// mine_lfsr: free-running 16-bit Fibonacci LFSR; clk/rst (sync, active-high), seed = reset value, out = current state.
module mine_lfsr
   import saper_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   output logic [15:0] out
);
   logic [15:0] lfsr_q, lfsr_d;
   always_comb lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
   always_ff @(posedge clk) lfsr_q <= rst ? seed : lfsr_d;
   assign out = lfsr_q;
endmodule

// File: rtl/mine_board_gen.sv
// mine_board_gen: places the level's mines at random distinct cells, avoiding the first-clicked field.
//   in : clk, rst (sync, active-high), level (1 easy/2 medium/3 hard, 0 none), start pulse, safe_x/safe_y
//   out: mine_arr_easy/medium/hard [x][y] maps, busy (CLEAR..DRAW), done pulse, mines_placed count
module mine_board_gen
   import saper_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          level,
   input  logic                start,
   input  logic [4:0]          safe_x,
   input  logic [4:0]          safe_y,
   output logic [7:0][7:0]     mine_arr_easy,
   output logic [9:0][9:0]     mine_arr_medium,
   output logic [15:0][15:0]   mine_arr_hard,
   output logic                busy,
   output logic                done,
   output logic [5:0]          mines_placed
);
   gen_state_t          state_q, state_d;
   logic [1:0]          lvl_q, lvl_d;
   logic [4:0]          sx_q, sx_d, sy_q, sy_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [7:0][7:0]     easy_q, easy_d;
   logic [9:0][9:0]     med_q, med_d;
   logic [15:0][15:0]   hard_q, hard_d;
   logic [15:0]         lfsr;
   logic [4:0]          cx, cy, sz;
   logic                hit, accept;
   mine_lfsr u_lfsr (.clk(clk), .rst(rst), .seed(LFSR_SEED), .out(lfsr));
   assign cx = lfsr[4:0];
   assign cy = lfsr[12:8];
   assign sz = board_size(lvl_q);
   // The array lookup may index past a small board; accept masks that case via the size check.
   assign hit = lvl_q == LVL_EASY ? easy_q[cx[2:0]][cy[2:0]] :
                lvl_q == LVL_MEDIUM ? med_q[cx[3:0]][cy[3:0]] : hard_q[cx[3:0]][cy[3:0]];
   assign accept = state_q == ST_DRAW && cx < sz && cy < sz && !(cx == sx_q && cy == sy_q) && !hit;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         lvl_q   <= LVL_NONE;
         sx_q    <= '0;
         sy_q    <= '0;
         cnt_q   <= '0;
         easy_q  <= '0;
         med_q   <= '0;
         hard_q  <= '0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         cnt_q   <= cnt_d;
         easy_q  <= easy_d;
         med_q   <= med_d;
         hard_q  <= hard_d;
      end
   end
   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      cnt_d   = cnt_q;
      easy_d  = easy_q;
      med_d   = med_q;
      hard_d  = hard_q;
      case (state_q)
         ST_IDLE: if (start && level != LVL_NONE) begin
            state_d = ST_CLEAR;
            lvl_d   = level;
            sx_d    = safe_x;
            sy_d    = safe_y;
         end
         ST_CLEAR: begin
            state_d = ST_DRAW;
            cnt_d   = '0;
            easy_d  = '0;
            med_d   = '0;
            hard_d  = '0;
         end
         ST_DRAW: if (accept) begin
            cnt_d = cnt_q + 6'd1;
            if (lvl_q == LVL_EASY) easy_d[cx[2:0]][cy[2:0]] = 1'b1;
            else if (lvl_q == LVL_MEDIUM) med_d[cx[3:0]][cy[3:0]] = 1'b1;
            else hard_d[cx[3:0]][cy[3:0]] = 1'b1;
            if (cnt_q + 6'd1 == mine_target(lvl_q)) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_comb begin
      busy = state_q == ST_CLEAR || state_q == ST_DRAW;
      done = state_q == ST_DONE;
   end
   assign mine_arr_easy   = easy_q;
   assign mine_arr_medium = med_q;
   assign mine_arr_hard   = hard_q;
   assign mines_placed    = cnt_q;
endmodule
